// File: rtl/ctrl_pkg.sv
// Shared encodings for the MIPS control path: opcodes, ALU ops, mux selects,
// controller states and instruction classes.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_XOR = 4'd3;
  localparam logic [3:0] ALU_NOR = 4'd4;
  localparam logic [3:0] ALU_SRL = 4'd5;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_SLL = 4'd8;

  localparam logic [1:0] PCS_PC4  = 2'b00;
  localparam logic [1:0] PCS_RS   = 2'b01;
  localparam logic [1:0] PCS_BR   = 2'b10;
  localparam logic [1:0] PCS_JT   = 2'b11;
  localparam logic [1:0] RDST_RD  = 2'b00;
  localparam logic [1:0] RDST_RT  = 2'b01;
  localparam logic [1:0] RDST_R31 = 2'b10;
  localparam logic [1:0] ASRC_RT    = 2'b00;
  localparam logic [1:0] ASRC_SHAMT = 2'b01;
  localparam logic [1:0] ASRC_SEXT  = 2'b10;
  localparam logic [1:0] ASRC_ZEXT  = 2'b11;
  localparam logic [1:0] M2R_ALU  = 2'b00;
  localparam logic [1:0] M2R_MEM  = 2'b01;
  localparam logic [1:0] M2R_PC4  = 2'b10;
  localparam logic [1:0] M2R_LUI  = 2'b11;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILL     = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ADDR,
    S_MEM, S_WB, S_BRANCH, S_JUMP, S_TRAP
  } state_e;

  typedef enum logic [4:0] {
    C_ILL, C_AND, C_OR, C_ADD, C_XOR, C_NOR, C_SUB, C_SLT, C_SRL, C_SLL,
    C_ADDI, C_ORI, C_LW, C_SW, C_BEQ, C_BNE, C_LUI, C_J, C_JAL, C_JR
  } iclass_e;

  function automatic logic [3:0] class_alu_op(input iclass_e c);
    case (c)
      C_OR, C_ORI:  return ALU_OR;
      C_ADD, C_ADDI: return ALU_ADD;
      C_XOR:        return ALU_XOR;
      C_NOR:        return ALU_NOR;
      C_SRL:        return ALU_SRL;
      C_SUB:        return ALU_SUB;
      C_SLT:        return ALU_SLT;
      C_SLL:        return ALU_SLL;
      default:      return ALU_AND;
    endcase
  endfunction

  function automatic logic is_shift(input iclass_e c);
    return (c == C_SRL) || (c == C_SLL);
  endfunction

endpackage

// File: rtl/instr_class_decode.sv
// Combinational opcode/func to instruction class; legal_o low for anything unsupported.
module instr_class_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] func_i,
  output iclass_e    cls_o,
  output logic       legal_o
);

  always_comb begin
    cls_o = C_ILL;
    case (opcode_i)
      OP_RTYPE: begin
        case (func_i)
          FN_AND:  cls_o = C_AND;
          FN_OR:   cls_o = C_OR;
          FN_ADD:  cls_o = C_ADD;
          FN_XOR:  cls_o = C_XOR;
          FN_NOR:  cls_o = C_NOR;
          FN_SUB:  cls_o = C_SUB;
          FN_SLT:  cls_o = C_SLT;
          FN_SRL:  cls_o = C_SRL;
          FN_SLL:  cls_o = C_SLL;
          FN_JR:   cls_o = C_JR;
          default: cls_o = C_ILL;
        endcase
      end
      OP_ADDI: cls_o = C_ADDI;
      OP_ORI:  cls_o = C_ORI;
      OP_LW:   cls_o = C_LW;
      OP_SW:   cls_o = C_SW;
      OP_BEQ:  cls_o = C_BEQ;
      OP_BNE:  cls_o = C_BNE;
      OP_LUI:  cls_o = C_LUI;
      OP_J:    cls_o = C_J;
      OP_JAL:  cls_o = C_JAL;
      default: cls_o = C_ILL;
    endcase
    legal_o = (cls_o != C_ILL);
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB with memory ready
// handshakes, optional wait timeout, and sticky traps for illegal ops and timeouts.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int unsigned ALUOP_W     = 4,
  parameter int unsigned MEM_TIMEOUT = 0,
  parameter int unsigned TO_CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         func,
  input  logic               zero,
  input  logic               imem_ready,
  input  logic               dmem_ready,
  output logic               imem_req,
  output logic               dmem_req,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic [1:0]         reg_dst,
  output logic               reg_src,
  output logic [1:0]         alu_src,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         mem2reg,
  output logic               reg_write,
  output logic               trap,
  output logic [1:0]         trap_cause,
  output logic               busy
);

  localparam logic [TO_CNT_W-1:0] TO_LAST =
    TO_CNT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  state_e                state_q, state_d;
  iclass_e               class_q, class_d;
  logic [1:0]            cause_q, cause_d;
  logic [TO_CNT_W-1:0]   cnt_q, cnt_d;
  iclass_e               dec_cls;
  logic                  dec_legal;
  logic                  timeout_hit;
  logic [3:0]            alu4;

  instr_class_decode u_dec (
    .opcode_i (opcode),
    .func_i   (func),
    .cls_o    (dec_cls),
    .legal_o  (dec_legal)
  );

  // cnt_q counts low-ready cycles already spent; this cycle is the last allowed one.
  assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt_q >= TO_LAST);

  always_comb begin
    state_d = state_q;
    class_d = class_q;
    cause_d = cause_q;
    cnt_d   = '0;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ready) begin
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        class_d = dec_cls;
        if (!dec_legal) begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILL;
        end else begin
          case (dec_cls)
            C_ADDI, C_ORI:    state_d = S_EXEC_I;
            C_LW, C_SW:       state_d = S_ADDR;
            C_BEQ, C_BNE:     state_d = S_BRANCH;
            C_LUI:            state_d = S_WB;
            C_J, C_JAL, C_JR: state_d = S_JUMP;
            default:          state_d = S_EXEC_R;
          endcase
        end
      end
      S_EXEC_R, S_EXEC_I: state_d = S_WB;
      S_ADDR:   state_d = S_MEM;
      S_MEM: begin
        if (dmem_ready) begin
          state_d = (class_q == C_LW) ? S_WB : S_FETCH;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_IDLE;
    endcase
    // Any state change (including wait-state entry) restarts the count from zero.
    if ((state_q == S_FETCH || state_q == S_MEM) && state_d == state_q) begin
      cnt_d = (cnt_q == {TO_CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      class_q <= C_ILL;
      cause_q <= CAUSE_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PCS_PC4;
    reg_dst   = RDST_RD;
    reg_src   = 1'b0;
    alu_src   = ASRC_RT;
    alu4      = ALU_AND;
    mem2reg   = M2R_ALU;
    reg_write = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_write = imem_ready;
        pc_write = imem_ready;
      end
      S_EXEC_R: begin
        alu4    = class_alu_op(class_q);
        alu_src = is_shift(class_q) ? ASRC_SHAMT : ASRC_RT;
        reg_src = is_shift(class_q);
      end
      S_EXEC_I: begin
        alu4    = class_alu_op(class_q);
        alu_src = (class_q == C_ADDI) ? ASRC_SEXT : ASRC_ZEXT;
      end
      S_ADDR: begin
        alu4    = ALU_ADD;
        alu_src = ASRC_SEXT;
      end
      S_MEM: begin
        dmem_req  = 1'b1;
        mem_read  = (class_q == C_LW);
        mem_write = (class_q == C_SW);
      end
      S_WB: begin
        reg_write = 1'b1;
        case (class_q)
          C_LW:         begin reg_dst = RDST_RT; mem2reg = M2R_MEM; end
          C_LUI:        begin reg_dst = RDST_RT; mem2reg = M2R_LUI; end
          C_ADDI, C_ORI: reg_dst = RDST_RT;
          default:      reg_dst = RDST_RD;
        endcase
      end
      S_BRANCH: begin
        alu4     = ALU_SUB;
        pc_src   = PCS_BR;
        pc_write = (class_q == C_BNE) ? !zero : zero;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = (class_q == C_JR) ? PCS_RS : PCS_JT;
        if (class_q == C_JAL) begin
          reg_write = 1'b1;
          reg_dst   = RDST_R31;
          mem2reg   = M2R_PC4;
        end
      end
      default: ;
    endcase
  end

  assign alu_op     = ALUOP_W'(alu4);
  assign trap       = (state_q == S_TRAP);
  assign trap_cause = cause_q;
  assign busy       = (state_q != S_IDLE) && (state_q != S_TRAP);

endmodule
